pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage MIPS core. It collects stall requests from IF, ID, EX and MEM and drives the `pause[5:0]` vector and the `clear` flush strobe consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb). When the MEM stage reports an exception or ERET, it also produces the redirect PC. Optionally, it defers the flush until outstanding instruction and data bus transactions have drained.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hBFC00380: general exception entry (BEV=1).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stallreq_if`  in  1  IF stage stall request (ibus not ready).
- `stallreq_id`  in  1  ID stage stall request (load-use hazard).
- `stallreq_ex`  in  1  EX stage stall request (multi-cycle mul/div).
- `stallreq_mem`  in  1  MEM stage stall request (dbus not ready).
- `mem_exception_type`  in  32  final exception code from MEM stage; 0 = none.
- `cp0_epc`  in  32  current EPC, already forwarded.
- `ibus_busy`  in  1  instruction bus has an outstanding transaction.
- `dbus_busy`  in  1  data bus has an outstanding transaction.
- `pause`  out  6  bit i stalls stage i (0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB).
- `clear`  out  1  flush all inter-stage registers this cycle.
- `new_pc`  out  32  redirect target; valid only while `clear`=1.
- `stall_cnt`  out  32  count of cycles in which `pause[0]`=1 and `clear`=0; saturating.

## Operation
- States: RUN and DRAIN. DRAIN exists only with the macro (see Configuration).
- In RUN with `mem_exception_type`==0, `pause` is decoded combinationally, highest stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- The pattern guarantees that the first un-stalled register downstream of a stall loads a bubble (`pause[k] & !pause[k+1]`).
- In RUN with `mem_exception_type`!=0 and no drain required:
  - `clear`=1 and `pause`=0 in the same cycle.
  - `new_pc` = `cp0_epc` when the type is 32'h0000000e (ERET).
  - Otherwise `new_pc` = `EXC_VECTOR`.
  - Exception takes priority over every stall request.
- In RUN with an exception and (`ibus_busy`|`dbus_busy`):
  - Latch the type and `cp0_epc` into internal registers.
  - Output `pause`=6'b111111, `clear`=0.
  - Next state: DRAIN.
- In DRAIN:
  - `pause`=6'b111111 and `clear`=0 while either bus is busy.
  - In the first cycle both busy lines are low: `clear`=1, `pause`=0, `new_pc` computed from the latched values. Next state: RUN.
  - Exception inputs and stall requests are ignored in DRAIN.
- Outside a flush, `new_pc` = 32'h0.

## Timing
- `pause`, `clear` and `new_pc` are combinational from inputs and state, so stage registers act at the next edge (zero-cycle control latency).
- `stall_cnt` is registered: it updates on the edge after the qualifying cycle and holds at 32'hFFFFFFFF.
- Reset (`rst`=0 at an edge):
  - state=RUN; latched type/EPC = 0; `stall_cnt`=0.
  - While `rst`=0, outputs are forced to `pause`=0, `clear`=0, `new_pc`=0.
  - Reset during DRAIN abandons the pending flush.
- DRAIN length is unbounded; it ends only on bus idle.
- Busy lines dropping in the cycle the exception arrives means no drain: immediate flush.

## Configuration
- `PIPE_CTRL_DRAIN_EN` defined: DRAIN state and latch registers are built; behaviour as above.
- Not defined: `ibus_busy`/`dbus_busy` are ignored, the DRAIN state does not exist, and every exception flushes in the cycle it is presented.

## Test plan
- Stall priority: `stallreq_id`=1, then `stallreq_ex`=1, then `stallreq_mem`=1, with `stallreq_if`=1 throughout -> `pause` = 6'b000111, 6'b001111, 6'b011111 in successive cycles. `stall_cnt` increments by 1 per cycle.
- Syscall: `mem_exception_type`=32'h8 with `stallreq_ex`=1, buses idle -> same cycle `clear`=1, `pause`=0, `new_pc`=32'hBFC00380.
- ERET: `mem_exception_type`=32'he, `cp0_epc`=32'h80001234 -> `clear`=1, `new_pc`=32'h80001234.
- Drain (macro on): exception 32'hc with `dbus_busy`=1 for 3 cycles, while `cp0_epc` and the type change mid-drain -> 3 cycles with `pause`=6'b111111, then one cycle with `clear`=1 and `new_pc`=32'hBFC00380, then RUN.
- Reset mid-drain: `rst`=0 during DRAIN -> next cycle `pause`=0, `clear`=0, `stall_cnt`=0; no flush afterwards.
- Saturation: preload via long stall (or force `stall_cnt`=32'hFFFFFFFE), hold `stallreq_if`=1 -> counter reaches 32'hFFFFFFFF and stays.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the five-stage MIPS core.
// Optional bus-drain before an exception flush is built when PIPE_CTRL_DRAIN_EN is defined.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] mem_exception_type,
    input  logic [31:0] cp0_epc,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    output logic [5:0]  pause,
    output logic        clear,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt
);

    localparam logic [31:0] ERET_CODE = 32'h0000000e;

    logic [5:0]  stall_pause;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Highest requesting stage wins; the first un-paused register downstream loads a bubble.
    always_comb begin
        if (stallreq_mem)
            stall_pause = 6'b011111;
        else if (stallreq_ex)
            stall_pause = 6'b001111;
        else if (stallreq_id)
            stall_pause = 6'b000111;
        else if (stallreq_if)
            stall_pause = 6'b000011;
        else
            stall_pause = 6'b000000;
    end

    function automatic logic [31:0] redirect_pc(input logic [31:0] exc_type,
                                                input logic [31:0] epc);
        return (exc_type == ERET_CODE) ? epc : EXC_VECTOR;
    endfunction

`ifdef PIPE_CTRL_DRAIN_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] exc_type_q, exc_type_d;
    logic [31:0] epc_q, epc_d;
    logic        bus_busy;

    assign bus_busy = ibus_busy | dbus_busy;

    always_comb begin
        pause      = 6'b000000;
        clear      = 1'b0;
        new_pc     = 32'h0;
        state_d    = state_q;
        exc_type_d = exc_type_q;
        epc_d      = epc_q;
        if (rst) begin
            if (state_q == ST_RUN) begin
                if (mem_exception_type != 32'h0) begin
                    if (bus_busy) begin
                        pause      = 6'b111111;
                        exc_type_d = mem_exception_type;
                        epc_d      = cp0_epc;
                        state_d    = ST_DRAIN;
                    end else begin
                        clear  = 1'b1;
                        new_pc = redirect_pc(mem_exception_type, cp0_epc);
                    end
                end else begin
                    pause = stall_pause;
                end
            end else begin
                // Live exception/stall inputs are ignored until both buses go idle.
                if (bus_busy) begin
                    pause = 6'b111111;
                end else begin
                    clear   = 1'b1;
                    new_pc  = redirect_pc(exc_type_q, epc_q);
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            exc_type_q <= 32'h0;
            epc_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            exc_type_q <= exc_type_d;
            epc_q      <= epc_d;
        end
    end
`else
    logic unused_bus_busy;
    assign unused_bus_busy = ibus_busy ^ dbus_busy;

    always_comb begin
        pause  = 6'b000000;
        clear  = 1'b0;
        new_pc = 32'h0;
        if (rst) begin
            if (mem_exception_type != 32'h0) begin
                clear  = 1'b1;
                new_pc = redirect_pc(mem_exception_type, cp0_epc);
            end else begin
                pause = stall_pause;
            end
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pause[0] && !clear && (stall_cnt_q != 32'hFFFFFFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_q <= 32'h0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl; drain sequences run when PIPE_CTRL_DRAIN_EN is defined.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] mem_exception_type;
    logic [31:0] cp0_epc;
    logic        ibus_busy, dbus_busy;
    logic [5:0]  pause;
    logic        clear;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;

    pipe_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (
        .clk                (clk),
        .rst                (rst),
        .stallreq_if        (stallreq_if),
        .stallreq_id        (stallreq_id),
        .stallreq_ex        (stallreq_ex),
        .stallreq_mem       (stallreq_mem),
        .mem_exception_type (mem_exception_type),
        .cp0_epc            (cp0_epc),
        .ibus_busy          (ibus_busy),
        .dbus_busy          (dbus_busy),
        .pause              (pause),
        .clear              (clear),
        .new_pc             (new_pc),
        .stall_cnt          (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  sreq;   // {mem, ex, id, if}
        logic [31:0] exc;
        logic [31:0] epc;
        logic [1:0]  busy;   // {dbus, ibus}
        logic [5:0]  exp_pause;
        logic        exp_clear;
        logic [31:0] exp_pc;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          vec_id = 0;
    logic [31:0] cnt_model = 32'h0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec%0d: got %h want %h", name, vec_id, got, want);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [31:0] e,
                                input logic [31:0] p, input logic [1:0] b, input logic [5:0] ep,
                                input logic ec, input logic [31:0] epc_exp);
        vec_t v;
        v.rst_n = r; v.sreq = s; v.exc = e; v.epc = p; v.busy = b;
        v.exp_pause = ep; v.exp_clear = ec; v.exp_pc = epc_exp;
        return v;
    endfunction

    // Drive one cycle at the falling edge, check combinational outputs and the counter
    // value accumulated from earlier cycles, then advance the counter model.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst                = v.rst_n;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = v.sreq;
        mem_exception_type = v.exc;
        cp0_epc            = v.epc;
        {dbus_busy, ibus_busy} = v.busy;
        #1;
        check32("pause",     {26'h0, pause}, {26'h0, v.exp_pause});
        check32("clear",     {31'h0, clear}, {31'h0, v.exp_clear});
        check32("new_pc",    new_pc,         v.exp_pc);
        check32("stall_cnt", stall_cnt,      cnt_model);
        if (!v.rst_n)
            cnt_model = 32'h0;
        else if (v.exp_pause[0] && !v.exp_clear && cnt_model != 32'hFFFFFFFF)
            cnt_model = cnt_model + 32'd1;
        vec_id++;
    endtask

    localparam logic [31:0] EV = 32'hBFC00380;
    vec_t tbl[$];

    initial begin
        rst = 1'b0;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
        mem_exception_type = 32'h0;
        cp0_epc = 32'h0;
        ibus_busy = 1'b0;
        dbus_busy = 1'b0;

        // Reset forces outputs low regardless of inputs
        tbl.push_back(mk(1'b0, 4'b1000, 32'h8, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        // Stall priority
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0, 32'h0,        2'b00, 6'b000011, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0011, 32'h0, 32'h0,        2'b00, 6'b000111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0101, 32'h0, 32'h0,        2'b00, 6'b001111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b1001, 32'h0, 32'h0,        2'b00, 6'b011111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b1111, 32'h0, 32'h0,        2'b00, 6'b011111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0100, 32'h0, 32'h0,        2'b00, 6'b001111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0, 32'h0,        2'b11, 6'b000011, 1'b0, 32'h0));
        // Exceptions with buses idle
        tbl.push_back(mk(1'b1, 4'b0100, 32'h8, 32'h0,        2'b00, 6'b000000, 1'b1, EV));
        tbl.push_back(mk(1'b1, 4'b1111, 32'he, 32'h80001234, 2'b00, 6'b000000, 1'b1, 32'h80001234));
        tbl.push_back(mk(1'b1, 4'b0000, 32'h4, 32'h80001234, 2'b00, 6'b000000, 1'b1, EV));
        tbl.push_back(mk(1'b1, 4'b0010, 32'h0, 32'h80001234, 2'b00, 6'b000111, 1'b0, 32'h0));
        tbl.push_back(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        foreach (tbl[i]) apply(tbl[i]);

`ifdef PIPE_CTRL_DRAIN_EN
        // Drain on dbus for 3 cycles; type/EPC change mid-drain must not matter
        apply(mk(1'b1, 4'b0000, 32'hc, 32'h80000000, 2'b10, 6'b111111, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b1111, 32'he, 32'h8000abcd, 2'b10, 6'b111111, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0001, 32'he, 32'h8000abcd, 2'b10, 6'b111111, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'he, 32'h8000ffff, 2'b00, 6'b000000, 1'b1, EV));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        // Latched ERET redirects to the EPC captured at entry
        apply(mk(1'b1, 4'b0000, 32'he, 32'h80005555, 2'b01, 6'b111111, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b1, 32'h80005555));
        apply(mk(1'b1, 4'b0001, 32'h0, 32'h0,        2'b00, 6'b000011, 1'b0, 32'h0));
        // Reset mid-drain abandons the flush
        apply(mk(1'b1, 4'b0000, 32'h8, 32'h0,        2'b10, 6'b111111, 1'b0, 32'h0));
        apply(mk(1'b0, 4'b0000, 32'h0, 32'h0,        2'b10, 6'b000000, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b10, 6'b000000, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
`else
        // Without drain support the busy lines are ignored
        apply(mk(1'b1, 4'b0000, 32'hc, 32'h80000000, 2'b10, 6'b000000, 1'b1, EV));
        apply(mk(1'b1, 4'b0000, 32'he, 32'h80005555, 2'b11, 6'b000000, 1'b1, 32'h80005555));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        apply(mk(1'b0, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0,        2'b00, 6'b000000, 1'b0, 32'h0));
`endif

        // Saturation: preload just below the top, then keep stalling
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_cnt_q;
        cnt_model = 32'hFFFFFFFE;
        apply(mk(1'b1, 4'b0001, 32'h0, 32'h0, 2'b00, 6'b000011, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0001, 32'h0, 32'h0, 2'b00, 6'b000011, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0001, 32'h0, 32'h0, 2'b00, 6'b000011, 1'b0, 32'h0));
        apply(mk(1'b1, 4'b0000, 32'h0, 32'h0, 2'b00, 6'b000000, 1'b0, 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
